// File: rtl/cdb_arbiter_if.sv
// Common-data-bus arbiter interface.
// Groups the requester handshake (flush, req_valid/tag/data, req_ready) and the
// registered broadcast (cdb_valid/tag/data, set_rob_valid, conflict_cnt).
//   master : the execute-unit side; drives requests and flush, observes grants/broadcast
//   slave  : the arbiter side; observes requests and flush, drives grants/broadcast
interface cdb_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_W     = 3,
    parameter int ROB_DEPTH = 8,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16
) ();
    logic                      flush;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [ROB_DEPTH-1:0]      set_rob_valid;
    logic [CNT_W-1:0]          conflict_cnt;

    modport master (
        output flush, req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, set_rob_valid, conflict_cnt
    );

    modport slave (
        input  flush, req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data, set_rob_valid, conflict_cnt
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the single common-data-bus broadcast slot.
// One execute unit is granted per cycle; the winner's ROB tag and data are
// registered onto the CDB for exactly one cycle, together with a one-hot
// set_rob_valid, and a saturating count of multi-request cycles is kept.
// Ports:
//   clk      : clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : cdb_arbiter_if.slave (flush, requests in; grant, broadcast, counter out)
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_W     = 3,
    parameter int ROB_DEPTH = 8,
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    cdb_arbiter_if.slave        bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic [CNT_W-1:0]   conflict_q, conflict_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [ROB_DEPTH-1:0] set_rob_d;

    // Grant selection: walk the requesters starting at rr_ptr, wrapping, and
    // take the first valid one. Flush and a held reset suppress the grant so a
    // unit never sees ready for a result that will not be broadcast.
    always_comb begin
        int  idx;
        int  reqCount;
        logic found;
        logic [PTR_W-1:0] winner;
        grant_d     = '0;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        conflict_d  = conflict_q;
        found       = 1'b0;
        winner      = '0;
        reqCount    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found      = 1'b1;
                winner     = PTR_W'(idx);
                cdb_tag_d  = bus.req_tag[idx*TAG_W +: TAG_W];
                cdb_data_d = bus.req_data[idx*DATA_W +: DATA_W];
            end
            if (bus.req_valid[k]) begin
                reqCount++;
            end
        end
        if (found && !bus.flush && reset_n) begin
            grant_d[winner] = 1'b1;
            cdb_valid_d     = 1'b1;
            rr_ptr_d        = (int'(winner) == NUM_REQ - 1) ? '0 : PTR_W'(int'(winner) + 1);
        end else begin
            cdb_tag_d  = cdb_tag_q;
            cdb_data_d = cdb_data_q;
        end
        // Conflict cycles are counted even under flush; the counter pins at all-ones.
        if (reqCount >= 2 && conflict_q != '1) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    // Broadcast, pointer and counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            conflict_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            conflict_q  <= conflict_d;
        end
    end

    // One-hot ROB completion strobe decoded from the registered broadcast.
    always_comb begin
        set_rob_d = '0;
        if (cdb_valid_q) begin
            set_rob_d[cdb_tag_q] = 1'b1;
        end
    end

    assign bus.req_ready     = grant_d;
    assign bus.cdb_valid     = cdb_valid_q;
    assign bus.cdb_tag       = cdb_tag_q;
    assign bus.cdb_data      = cdb_data_q;
    assign bus.set_rob_valid = set_rob_d;
    assign bus.conflict_cnt  = conflict_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter: reset, single request, round robin,
// wrap/fairness, flush, and counter saturation with async reset.
module tb_cdb_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 3;
    localparam int DATA_W  = 32;

    logic clk = 1'b0;
    logic reset_n;
    logic reset2_n;
    int   checkCount = 0;
    int   errorCount = 0;

    cdb_arbiter_if #(.NUM_REQ(4), .TAG_W(3), .ROB_DEPTH(8), .DATA_W(32), .CNT_W(16)) ifA ();
    cdb_arbiter_if #(.NUM_REQ(4), .TAG_W(3), .ROB_DEPTH(8), .DATA_W(32), .CNT_W(2))  ifB ();

    cdb_arbiter #(.NUM_REQ(4), .TAG_W(3), .ROB_DEPTH(8), .DATA_W(32), .CNT_W(16)) dutA (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifA.slave)
    );

    cdb_arbiter #(.NUM_REQ(4), .TAG_W(3), .ROB_DEPTH(8), .DATA_W(32), .CNT_W(2)) dutB (
        .clk     (clk),
        .reset_n (reset2_n),
        .bus     (ifB.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive flush and the valid vector of the main DUT, then let combinational logic settle.
    task automatic applyStimulus(input logic f, input logic [NUM_REQ-1:0] v);
        ifA.flush     = f;
        ifA.req_valid = v;
        #1;
    endtask

    // Load the tag and data presented by one unit of the main DUT.
    task automatic setUnit(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        ifA.req_tag[i*TAG_W +: TAG_W]    = t;
        ifA.req_data[i*DATA_W +: DATA_W] = d;
    endtask

    // Advance to just after the next rising edge.
    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        reset2_n     = 1'b0;
        ifA.req_tag  = '0;
        ifA.req_data = '0;
        ifB.flush     = 1'b0;
        ifB.req_valid = '0;
        ifB.req_tag   = '0;
        ifB.req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            setUnit(i, TAG_W'(i + 1), 32'hA0 + 32'(i));
        end
        applyStimulus(1'b0, 4'b1111);

        // Reset held with all requesters valid
        nextEdge();
        nextEdge();
        checkOutput("rstReady",  64'(ifA.req_ready),     64'h0);
        checkOutput("rstValid",  64'(ifA.cdb_valid),     64'h0);
        checkOutput("rstSetRob", 64'(ifA.set_rob_valid), 64'h0);
        checkOutput("rstTag",    64'(ifA.cdb_tag),       64'h0);
        checkOutput("rstData",   64'(ifA.cdb_data),      64'h0);
        checkOutput("rstCnt",    64'(ifA.conflict_cnt),  64'h0);
        reset_n = 1'b1;
        #1;
        checkOutput("firstGrant", 64'(ifA.req_ready), 64'b0001);

        // Round robin: each unit drops valid after its grant
        nextEdge();
        applyStimulus(1'b0, 4'b1110);
        checkOutput("rr0Valid",  64'(ifA.cdb_valid),     64'h1);
        checkOutput("rr0Tag",    64'(ifA.cdb_tag),       64'h1);
        checkOutput("rr0Data",   64'(ifA.cdb_data),      64'hA0);
        checkOutput("rr0SetRob", 64'(ifA.set_rob_valid), 64'h02);
        checkOutput("rr1Ready",  64'(ifA.req_ready),     64'b0010);
        checkOutput("rr0Cnt",    64'(ifA.conflict_cnt),  64'd1);
        nextEdge();
        applyStimulus(1'b0, 4'b1100);
        checkOutput("rr1Tag",    64'(ifA.cdb_tag),       64'h2);
        checkOutput("rr1SetRob", 64'(ifA.set_rob_valid), 64'h04);
        checkOutput("rr2Ready",  64'(ifA.req_ready),     64'b0100);
        checkOutput("rr1Cnt",    64'(ifA.conflict_cnt),  64'd2);
        nextEdge();
        applyStimulus(1'b0, 4'b1000);
        checkOutput("rr2Tag",    64'(ifA.cdb_tag),       64'h3);
        checkOutput("rr2Data",   64'(ifA.cdb_data),      64'hA2);
        checkOutput("rr3Ready",  64'(ifA.req_ready),     64'b1000);
        nextEdge();
        applyStimulus(1'b0, 4'b0000);
        checkOutput("rr3Valid",  64'(ifA.cdb_valid),     64'h1);
        checkOutput("rr3Tag",    64'(ifA.cdb_tag),       64'h4);
        checkOutput("rr3SetRob", 64'(ifA.set_rob_valid), 64'h10);
        checkOutput("rrIdleRdy", 64'(ifA.req_ready),     64'h0);
        checkOutput("rrCnt",     64'(ifA.conflict_cnt),  64'd3);
        nextEdge();
        checkOutput("idleValid",  64'(ifA.cdb_valid),     64'h0);
        checkOutput("idleTag",    64'(ifA.cdb_tag),       64'h4);
        checkOutput("idleData",   64'(ifA.cdb_data),      64'hA3);
        checkOutput("idleSetRob", 64'(ifA.set_rob_valid), 64'h0);

        // Single request from unit 2
        setUnit(2, 3'd5, 32'h0000000B);
        applyStimulus(1'b0, 4'b0100);
        checkOutput("singleReady", 64'(ifA.req_ready), 64'b0100);
        nextEdge();
        applyStimulus(1'b0, 4'b0000);
        checkOutput("singleValid",  64'(ifA.cdb_valid),     64'h1);
        checkOutput("singleTag",    64'(ifA.cdb_tag),       64'h5);
        checkOutput("singleData",   64'(ifA.cdb_data),      64'hB);
        checkOutput("singleSetRob", 64'(ifA.set_rob_valid), 64'b0010_0000);

        // Wrap and fairness: units 3 and 0 always valid starting at pointer 3
        setUnit(3, 3'd6, 32'hC3);
        setUnit(0, 3'd7, 32'hC0);
        applyStimulus(1'b0, 4'b1001);
        checkOutput("wrapG1", 64'(ifA.req_ready), 64'b1000);
        nextEdge();
        checkOutput("wrapTag1", 64'(ifA.cdb_tag),   64'h6);
        checkOutput("wrapG2",   64'(ifA.req_ready), 64'b0001);
        nextEdge();
        checkOutput("wrapTag2", 64'(ifA.cdb_tag),   64'h7);
        checkOutput("wrapG3",   64'(ifA.req_ready), 64'b1000);
        nextEdge();
        checkOutput("wrapTag3", 64'(ifA.cdb_tag),   64'h6);
        checkOutput("wrapData3", 64'(ifA.cdb_data), 64'hC3);
        checkOutput("wrapG4",   64'(ifA.req_ready), 64'b0001);
        nextEdge();

        // Flush while units 1 and 3 request; the in-flight broadcast still shows
        setUnit(1, 3'd2, 32'h55);
        applyStimulus(1'b1, 4'b1010);
        checkOutput("wrapCnt",    64'(ifA.conflict_cnt), 64'd7);
        checkOutput("flushReady", 64'(ifA.req_ready),    64'h0);
        checkOutput("flushShown", 64'(ifA.cdb_valid),    64'h1);
        checkOutput("flushTag",   64'(ifA.cdb_tag),      64'h7);
        nextEdge();
        checkOutput("postFlushValid", 64'(ifA.cdb_valid),    64'h0);
        checkOutput("postFlushTag",   64'(ifA.cdb_tag),      64'h7);
        checkOutput("postFlushCnt",   64'(ifA.conflict_cnt), 64'd8);
        applyStimulus(1'b0, 4'b1010);
        checkOutput("flushPtrHeld", 64'(ifA.req_ready), 64'b0010);
        nextEdge();
        applyStimulus(1'b0, 4'b0000);
        checkOutput("flushBcValid", 64'(ifA.cdb_valid),    64'h1);
        checkOutput("flushBcTag",   64'(ifA.cdb_tag),      64'h2);
        checkOutput("flushBcData",  64'(ifA.cdb_data),     64'h55);
        checkOutput("flushBcCnt",   64'(ifA.conflict_cnt), 64'd9);

        // Saturation on the 2-bit counter instance, then async reset mid-stream
        reset2_n      = 1'b1;
        ifB.req_valid = 4'b0011;
        #1;
        nextEdge();
        nextEdge();
        checkOutput("satCnt2", 64'(ifB.conflict_cnt), 64'd2);
        nextEdge();
        checkOutput("satCnt3", 64'(ifB.conflict_cnt), 64'd3);
        nextEdge();
        checkOutput("satCnt4", 64'(ifB.conflict_cnt), 64'd3);
        nextEdge();
        checkOutput("satCnt5", 64'(ifB.conflict_cnt), 64'd3);
        reset2_n = 1'b0;
        #1;
        checkOutput("asyncRstCnt",   64'(ifB.conflict_cnt), 64'd0);
        checkOutput("asyncRstValid", 64'(ifB.cdb_valid),    64'h0);
        checkOutput("asyncRstReady", 64'(ifB.req_ready),    64'h0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
